// File: rtl/soc_system_adder_ctrl.sv
// soc_system_adder_ctrl: Avalon-MM slave that adds two 32-bit operands serially,
// CHUNK_W bits per cycle, and publishes the sum on result_out for the adder PIO.
// CHUNK_W must be one of 1, 2, 4, 8, 16 or 32.
// Optional feature macro: SOC_SYSTEM_ADDER_CTRL_IRQ_EN adds a registered done
// interrupt (irq = done & irq_enable) and makes STATUS bit3 live.
// Register map (word address): 0 OP_A, 1 OP_B, 2 CTRL/STATUS, 3 RESULT.
//   CTRL write: bit0 start, bit1 clear done, bit2 irq_enable.
//   STATUS read: bit0 busy, bit1 done, bit2 carry, bit3 irq_enable.
module soc_system_adder_ctrl #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] result_out
`ifdef SOC_SYSTEM_ADDER_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int unsigned NumChunks = 32 / CHUNK_W;
    localparam logic [5:0]  LastCnt   = 6'(NumChunks - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q, state_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [31:0]   wa_q, wa_d;
    logic [31:0]   wb_q, wb_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          carry_q, carry_d;
    logic          st_carry_q, st_carry_d;
    logic          done_q, done_d;
    logic          irq_en_q, irq_en_d;
    logic [5:0]    cnt_q, cnt_d;

    logic          ctrl_wr;
    logic          start;
    logic          finish;
    logic [CHUNK_W:0] chunk_sum;
    logic [31:0]   acc_shift;
    logic [31:0]   status;

    // Bus decode and the per-cycle chunk adder.
    always_comb begin
        ctrl_wr   = chipselect && write && (address == 2'd2);
        start     = ctrl_wr && writedata[0] && (state_q == StIdle);
        finish    = (state_q == StRun) && (cnt_q == LastCnt);
        chunk_sum = {1'b0, wa_q[CHUNK_W-1:0]} + {1'b0, wb_q[CHUNK_W-1:0]}
                  + {{CHUNK_W{1'b0}}, carry_q};
        // Sum chunks enter at the MSB end; after NumChunks shifts the word is in order.
        acc_shift = (acc_q >> CHUNK_W) | (32'(chunk_sum[CHUNK_W-1:0]) << (32 - CHUNK_W));
        status    = {28'd0, irq_en_q, st_carry_q, done_q, (state_q == StRun)};
    end

    // Next-state logic: FSM, operand registers, serial datapath, status and read mux.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        wa_d       = wa_q;
        wb_d       = wb_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        st_carry_d = st_carry_q;
        done_d     = done_q;
        irq_en_d   = irq_en_q;
        rdata_d    = 32'd0;

        // Operand registers stay writable while running; the snapshot isolates the sum.
        if (chipselect && write && (address == 2'd0)) op_a_d = writedata;
        if (chipselect && write && (address == 2'd1)) op_b_d = writedata;

`ifdef SOC_SYSTEM_ADDER_CTRL_IRQ_EN
        if (ctrl_wr) irq_en_d = writedata[2];
`else
        irq_en_d = 1'b0;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    wa_d    = op_a_q;
                    wb_d    = op_b_q;
                    acc_d   = 32'd0;
                    carry_d = 1'b0;
                    cnt_d   = 6'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                wa_d    = wa_q >> CHUNK_W;
                wb_d    = wb_q >> CHUNK_W;
                acc_d   = acc_shift;
                carry_d = chunk_sum[CHUNK_W];
                cnt_d   = cnt_q + 6'd1;
                if (finish) begin
                    result_d   = acc_shift;
                    st_carry_d = chunk_sum[CHUNK_W];
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set is applied after clear so a completion wins over a same-edge clear.
        if (ctrl_wr && writedata[1]) done_d = 1'b0;
        if (finish)                  done_d = 1'b1;

        case (address)
            2'd0:    rdata_d = op_a_q;
            2'd1:    rdata_d = op_b_q;
            2'd2:    rdata_d = status;
            default: rdata_d = result_q;
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            wa_q       <= 32'd0;
            wb_q       <= 32'd0;
            acc_q      <= 32'd0;
            carry_q    <= 1'b0;
            cnt_q      <= 6'd0;
            result_q   <= 32'd0;
            st_carry_q <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            wa_q       <= wa_d;
            wb_q       <= wb_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            st_carry_q <= st_carry_d;
            done_q     <= done_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef SOC_SYSTEM_ADDER_CTRL_IRQ_EN
    logic irq_q;

    // Registered interrupt: follows done & irq_enable one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done_q & irq_en_q;
        end
    end

    assign irq = irq_q;
`endif

    assign readdata   = rdata_q;
    assign result_out = result_q;

endmodule
